// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for the 5-stage core. Resolves the
//               hazards forwarding cannot cover: load-use stalls, wrong-path
//               flushes on a taken branch resolved in EX, and whole-pipe
//               freezes while a data-memory access in MEM is outstanding.
//               Also flags over-long memory waits (sticky) and keeps
//               saturating stall / flush performance counters.
// Ports       : clk, rst_n                  clock, async active-low reset
//               ID_rs1/2, ID_use_rs1/2      ID-stage source operands
//               EX_rd, EX_memread           EX-stage load destination
//               EX_branch_taken             taken branch resolved in EX
//               MEM_req, MEM_ready          MEM-stage access handshake
//               PC_write, IF_ID_write       front-end update enables
//               IF_ID_flush, ID_EX_flush    bubble insertion
//               pipe_hold, MEM_WB_flush     memory-wait freeze controls
//               mem_timeout                 sticky wait-overrun flag
//               stall_cycles, flush_count   saturating perf counters
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic [4:0]       EX_rd,
    input  logic             EX_memread,
    input  logic             EX_branch_taken,
    input  logic             MEM_req,
    input  logic             MEM_ready,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             pipe_hold,
    output logic             MEM_WB_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int              c_WAIT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [c_WAIT_W-1:0] c_MAX_WAIT = c_WAIT_W'(MAX_WAIT);

    localparam logic [0:0] c_ST_RUN      = 1'b0;
    localparam logic [0:0] c_ST_MEM_WAIT = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_cnt_nxt;
    logic                r_mem_timeout;
    logic                w_mem_timeout_nxt;
    logic [CNT_W-1:0]    r_stall_cycles;
    logic [CNT_W-1:0]    r_flush_count;

    logic w_mem_stall;
    logic w_load_use;
    logic w_stall_event;
    logic w_flush_event;

    assign w_mem_stall = MEM_req & ~MEM_ready;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign w_load_use = EX_memread & (EX_rd != 5'd0) &
                        ((ID_use_rs1 & (ID_rs1 == EX_rd)) |
                         (ID_use_rs2 & (ID_rs2 == EX_rd)));

    // A load-use under a taken branch is not a stall: ID holds a wrong-path op.
    assign w_stall_event = w_mem_stall | (w_load_use & ~EX_branch_taken);
    // While memory stalls, the branch stays parked in EX and is counted on release.
    assign w_flush_event = EX_branch_taken & ~w_mem_stall;

    // ------------------------------------------------------------------------
    // Control outputs: purely combinational, priority-ordered. rst_n gates
    // them directly so the pipe is held in a clean bubbled state during reset.
    // ------------------------------------------------------------------------
    always_comb begin
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        pipe_hold    = 1'b0;
        MEM_WB_flush = 1'b0;
        if (!rst_n) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            MEM_WB_flush = 1'b1;
        end else if (w_mem_stall) begin
            pipe_hold    = 1'b1;
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            MEM_WB_flush = 1'b1;
        end else if (EX_branch_taken) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
        end else if (w_load_use) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_flush  = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Memory-wait tracker: only observes the wait, never aborts the access.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_mem_timeout_nxt = r_mem_timeout;
        case (r_state)
            c_ST_RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt    = c_ST_MEM_WAIT;
                    w_wait_cnt_nxt = c_WAIT_W'(1);
                end
            end
            c_ST_MEM_WAIT: begin
                if (MEM_ready || !MEM_req) begin
                    w_state_nxt    = c_ST_RUN;
                    w_wait_cnt_nxt = '0;
                end else begin
                    if (r_wait_cnt != c_MAX_WAIT) begin
                        w_wait_cnt_nxt = r_wait_cnt + c_WAIT_W'(1);
                    end
                    if (r_wait_cnt == c_MAX_WAIT) begin
                        w_mem_timeout_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt    = c_ST_RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_mem_timeout <= w_mem_timeout_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Saturating performance counters.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall_event && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_flush_event && (r_flush_count != {CNT_W{1'b1}})) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign mem_timeout  = r_mem_timeout;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule
`default_nettype wire
